hack_instr_encoder: RTL
=======================

Name: hack_instr_encoder

Overview:
- Inverse of the CPU instruction demultiplexer: takes field-level instruction descriptions (type, value, a, comp, dest, jump) and packs them into 16-bit Hack-format words.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory through a request/acknowledge write port.
- Used as the program loader in front of the CPU's instruction ROM.

Parameters:
- DW, 16, instruction word width (fixed Hack format, must be 16).
- AW, 15, instruction memory address width.
- DEPTH, 4, encoded-word FIFO depth (power of two, >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  field set valid.
- in_ready  output  1  encoder can accept a field set.
- in_type  input  1  0 = A-instruction, 1 = C-instruction.
- in_value  input  DW-1  A-instruction constant (ignored for C).
- in_a  input  1  comp a-bit (ignored for A).
- in_comp  input  6  c1..c6, c1 = MSB (ignored for A).
- in_dest  input  3  d1..d3, d1 = MSB (ignored for A).
- in_jump  input  3  j1..j3, j1 = MSB (ignored for A).
- addr_load  input  1  load write pointer from start_addr.
- start_addr  input  AW  new write address.
- mem_we  output  1  write request.
- mem_addr  output  AW  write address.
- mem_wdata  output  DW  encoded instruction.
- mem_ack  input  1  memory accepted current write.
- busy  output  1  FIFO non-empty or write pending.
- wrap  output  1  sticky: address wrapped past 2^AW-1.
- load_err  output  1  one-cycle pulse: addr_load rejected.

Behaviour:
- Encoding (combinational at FIFO input):
  - A-instruction: word = {1'b0, in_value}.
  - C-instruction: word = {3'b111, in_a, in_comp, in_dest, in_jump}.
  - Ignored fields do not affect the word.
- Input handshake:
  - Transfer occurs when in_valid && in_ready on a rising edge.
  - in_ready = !fifo_full. It depends only on registered state, never on in_valid.
  - A push while full is impossible by construction.
  - Push and pop in the same cycle are both honoured, and the FIFO count is unchanged.
- FIFO: DEPTH entries, wrapping read/write pointers, count register 0..DEPTH.
- Write FSM states: IDLE, WRITE.
  - IDLE -> WRITE when the FIFO is non-empty. mem_we=1, mem_wdata=FIFO head, mem_addr=write pointer, all registered.
  - WRITE: mem_we, mem_addr and mem_wdata are held stable until mem_ack=1.
  - On ack: pop head and increment address.
  - After ack, stay in WRITE with the next head if the FIFO still holds data after the pop; otherwise go to IDLE with mem_we=0 the next cycle.
  - mem_ack while mem_we=0 is ignored.
- Latency:
  - Word accepted at edge N (FIFO empty, IDLE) gives mem_we=1 with that word after edge N+1.
  - With mem_ack held high, throughput is one word per cycle.
- Address:
  - Increments by 1 per acknowledged write, modulo 2^AW.
  - Increment from 2^AW-1 to 0 sets wrap. wrap stays set until reset or an accepted addr_load.
- addr_load:
  - Accepted only when in IDLE and the FIFO is empty. Then: pointer <= start_addr, wrap <= 0.
  - Otherwise ignored; load_err = 1 for exactly one cycle and the pointer is unchanged.
  - addr_load in the same cycle as an accepted push (FIFO empty, IDLE) is still accepted. The pushed word is written at start_addr.
- busy = (FIFO count != 0) || mem_we.
- Reset (asynchronous, any state including mid-WRITE):
  - Outputs: mem_we=0, mem_addr=0, mem_wdata=0, wrap=0, load_err=0, busy=0, in_ready=1 after release.
  - Internal state: FIFO emptied, FSM=IDLE.
  - A pending write is abandoned and not retried.

Test Plan:
- A-instr in_value=0x0015, mem_ack tied 1 -> mem_we one cycle after accept; mem_addr=0, mem_wdata=0x0015; then IDLE, busy=0.
- C-instr D=D+1 (a=0, comp=011111, dest=010, jump=000), then 0;JMP (a=0, comp=101010, dest=000, jump=111), ack tied 1 -> consecutive writes 0xE7D0 @0 and 0xEA87 @1.
- Push 5 words with mem_ack=0 -> in_ready drops after 4 accepted; mem_we/addr/data stable on word 0; ack once -> in_ready=1 next cycle, 5th word accepted; order preserved.
- addr_load with start_addr=0x7FFF, then 2 words, ack=1 -> writes @0x7FFF then @0x0000; wrap=1 and stays 1; second addr_load in IDLE clears it.
- addr_load while mem_we=1 -> load_err single-cycle pulse; write sequence and addresses unaffected.
- Assert rst_n=0 mid-WRITE with 3 words queued -> immediate mem_we=0, busy=0, mem_addr=0; after release, no stale writes appear.

Source files
------------

// File: rtl/hack_instr_encoder.sv
// Hack instruction encoder and program loader. It packs field-level instructions into
// 16-bit words, queues them in a small FIFO and writes them into instruction memory.
module hack_instr_encoder #(
  parameter int DW    = 16,
  parameter int AW    = 15,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_type,
  input  logic [DW-2:0] in_value,
  input  logic          in_a,
  input  logic [5:0]    in_comp,
  input  logic [2:0]    in_dest,
  input  logic [2:0]    in_jump,
  input  logic          addr_load,
  input  logic [AW-1:0] start_addr,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          wrap,
  output logic          load_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_WRITE = 1'b1;

  function automatic logic [DW-1:0] encode(
    input logic          typ,
    input logic [DW-2:0] value,
    input logic          a,
    input logic [5:0]    comp,
    input logic [2:0]    dest,
    input logic [2:0]    jump
  );
    if (typ) return {3'b111, a, comp, dest, jump};
    else     return {1'b0, value};
  endfunction

  logic [DW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [PW:0]   count;
  logic          state;
  logic [AW-1:0] waddr;
  logic          push, pop, load_ok, more;
  logic [DW-1:0] enc_word, next_head;

  assign enc_word = encode(in_type, in_value, in_a, in_comp, in_dest, in_jump);
  assign in_ready = (count != CNT_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == ST_WRITE) && mem_ack;
  assign load_ok  = addr_load && (state == ST_IDLE) && (count == '0);
  assign rd_nxt   = rd_ptr + PW'(1);
  // After a pop the next head is either still queued or is being pushed right now.
  assign more      = (count > CNT_ONE) || push;
  assign next_head = (count > CNT_ONE) ? fifo_mem[rd_nxt] : enc_word;
  assign mem_addr  = waddr;
  assign busy      = (count != '0) || mem_we;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      state     <= ST_IDLE;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      waddr     <= '0;
      wrap      <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      count    <= count + (PW+1)'(push) - (PW+1)'(pop);
      load_err <= addr_load && !load_ok;

      if (load_ok) begin
        waddr <= start_addr;
        wrap  <= 1'b0;
      end else if (pop) begin
        waddr <= waddr + AW'(1);
        if (waddr == '1) wrap <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            state     <= ST_WRITE;
            mem_we    <= 1'b1;
            mem_wdata <= fifo_mem[rd_ptr];
          end
        end
        default: begin
          if (mem_ack) begin
            if (more) begin
              mem_wdata <= next_head;
            end else begin
              state  <= ST_IDLE;
              mem_we <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule
